// File: rtl/sqrt_arbiter_if.sv
// sqrt_arbiter_if: signal bundle between the requesters, sqrt_arbiter and the
// shared sqrt unit.
//   req_i/a_i       : per-requester request level and packed 10-bit operands
//   gnt_o/done_o    : one-hot grant / result-valid pulses
//   y_o/busy_o      : last root, arbiter-busy flag
//   sq_start_o/sq_a_o, sq_busy_i/sq_y_i : handshake with the sqrt unit
// slave modport is the arbiter side, master modport is the environment side.
interface sqrt_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned OP_W = 10;
  localparam int unsigned RT_W = 5;

  logic [NUM_REQ-1:0]      req_i;
  logic [NUM_REQ*OP_W-1:0] a_i;
  logic [NUM_REQ-1:0]      gnt_o;
  logic [NUM_REQ-1:0]      done_o;
  logic [RT_W-1:0]         y_o;
  logic                    busy_o;
  logic                    sq_start_o;
  logic [OP_W-1:0]         sq_a_o;
  logic [1:0]              sq_busy_i;
  logic [RT_W-1:0]         sq_y_i;

  modport slave (
    input  req_i, a_i, sq_busy_i, sq_y_i,
    output gnt_o, done_o, y_o, busy_o, sq_start_o, sq_a_o
  );

  modport master (
    output req_i, a_i, sq_busy_i, sq_y_i,
    input  gnt_o, done_o, y_o, busy_o, sq_start_o, sq_a_o
  );
endinterface

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: shares one sqrt unit between NUM_REQ requesters. Picks a winner
// (round-robin by default), latches its operand, drives the unit through
// start/busy/done and returns the root with a one-cycle done pulse.
// Ports:
//   clk_i  : system clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : sqrt_arbiter_if.slave (requests, grants, results, sqrt handshake)
// Optional feature: define SQRT_ARB_FIXED_PRIO_EN for fixed priority
// (lowest requesting index always wins, no rotation pointer).
module sqrt_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  sqrt_arbiter_if.slave bus
);
  localparam int unsigned OP_W = 10;
  localparam int unsigned RT_W = 5;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [OP_W-1:0]    opnd_q, opnd_d;
  logic [RT_W-1:0]    y_q, y_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
`ifndef SQRT_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]   ptr_q, ptr_d;
`endif

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic [OP_W-1:0]    pick_op;
  logic               sq_busy;

  assign sq_busy = |bus.sq_busy_i;

  // Winner search: first set request starting at the pointer, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef SQRT_ARB_FIXED_PRIO_EN
      cand = IDX_W'(i);
`else
      cand = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
`endif
      if (!pick_vld && bus.req_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Operand of the selected requester.
  always_comb begin
    pick_op = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == IDX_W'(k)) pick_op = bus.a_i[k*OP_W +: OP_W];
    end
  end

  // Next state and next registered outputs; gnt/start/done are produced on the
  // transition so the registered copies appear in ISSUE / RESP.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    opnd_d  = opnd_q;
    y_d     = y_q;
    gnt_d   = '0;
    done_d  = '0;
    start_d = 1'b0;
`ifndef SQRT_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          win_d   = pick_idx;
          opnd_d  = pick_op;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (sq_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!sq_busy) begin
          y_d     = bus.sq_y_i;
          done_d  = NUM_REQ'(1) << win_q;
          state_d = RESP;
        end
      end
      RESP: begin
`ifndef SQRT_ARB_FIXED_PRIO_EN
        ptr_d   = IDX_W'((32'(win_q) + 1) % NUM_REQ);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      win_q   <= '0;
      opnd_q  <= '0;
      y_q     <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
`ifndef SQRT_ARB_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      opnd_q  <= opnd_d;
      y_q     <= y_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      start_q <= start_d;
      busy_q  <= busy_d;
`ifndef SQRT_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.gnt_o      = gnt_q;
  assign bus.done_o     = done_q;
  assign bus.y_o        = y_q;
  assign bus.busy_o     = busy_q;
  assign bus.sq_start_o = start_q;
  assign bus.sq_a_o     = opnd_q;
endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter: drives sqrt_arbiter with directed and random requesters and
// a behavioural 11-cycle sqrt unit; compares every cycle against a job-timeline
// reference model (winner rule, operand latch, floor sqrt).
module tb_sqrt_arbiter;
  localparam int NR = 4;
`ifdef SQRT_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sqrt_arbiter_if #(.NUM_REQ(NR)) bus ();

  sqrt_arbiter #(.NUM_REQ(NR)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  function automatic int isqrt(input int a);
    int r = 0;
    while ((r + 1) * (r + 1) <= a) r++;
    return r;
  endfunction

  // Stand-in sqrt unit: 11 busy cycles after start, random nonzero busy code,
  // garbage on the result while busy.
  int         su_cnt;
  logic [4:0] su_res;
  logic [1:0] su_code;
  logic [4:0] su_junk;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      su_cnt <= 0;
      su_res <= '0;
    end else if (bus.sq_start_o) begin
      su_cnt <= 11;
      su_res <= 5'(isqrt(int'(bus.sq_a_o)));
    end else if (su_cnt != 0) begin
      su_cnt <= su_cnt - 1;
    end
    su_code <= 2'($urandom_range(1, 3));
    su_junk <= 5'($urandom);
  end
  assign bus.sq_busy_i = (su_cnt != 0) ? su_code : 2'b00;
  assign bus.sq_y_i    = (su_cnt != 0) ? su_junk : su_res;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Requester agent state
  logic [NR-1:0] pend = '0, keep = '0, scram = '0;
  logic [9:0]    op [NR];
  bit            rnd_en = 1'b0;

  // Reference model: job timeline, m_t = cycle index since the IDLE sample
  bit m_act = 1'b0;
  int m_t = 0, m_w = 0, m_last = NR - 1, m_op = 0, m_y = 0;
  int glog[$], ylog[$], dlog[$];

  function automatic int pick(input logic [NR-1:0] r, input int last);
    int start = FIXED ? 0 : (last + 1) % NR;
    for (int i = 0; i < NR; i++) begin
      int k = (start + i) % NR;
      if (r[k]) return k;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_act = 1'b0; m_t = 0; m_w = 0; m_last = NR - 1; m_op = 0; m_y = 0;
  endtask

  // One clock: check outputs of this cycle, react, drive, advance the model.
  task automatic step();
    logic [NR-1:0]    e_gnt, e_done;
    logic [NR*10-1:0] av;
    @(negedge clk);
    cyc++;
    e_gnt  = (m_act && m_t == 1)  ? NR'(1) << m_w : '0;
    e_done = (m_act && m_t == 14) ? NR'(1) << m_w : '0;
    chk("gnt",   32'(bus.gnt_o),      32'(e_gnt));
    chk("done",  32'(bus.done_o),     32'(e_done));
    chk("start", 32'(bus.sq_start_o), (m_act && m_t == 1) ? 32'd1 : 32'd0);
    chk("busy",  32'(bus.busy_o),     m_act ? 32'd1 : 32'd0);
    chk("sq_a",  32'(bus.sq_a_o),     32'(m_op));
    chk("y",     32'(bus.y_o),        32'(m_y));
    for (int k = 0; k < NR; k++) begin
      if (bus.gnt_o[k]) glog.push_back(k);
      if (bus.done_o[k]) begin
        ylog.push_back(int'(bus.y_o));
        dlog.push_back(cyc);
      end
    end
    for (int k = 0; k < NR; k++) begin
      if (bus.gnt_o[k] && pend[k]) begin
        if (scram[k]) op[k] = 10'($urandom);
        if (keep[k]) begin
          if (rnd_en) begin
            op[k]   = 10'($urandom);
            keep[k] = ($urandom_range(0, 3) == 0);
          end
        end else begin
          pend[k] = 1'b0;
        end
      end
      if (rnd_en && !pend[k] && $urandom_range(0, 9) == 0) begin
        pend[k]  = 1'b1;
        op[k]    = 10'($urandom);
        keep[k]  = ($urandom_range(0, 3) == 0);
        scram[k] = 1'($urandom_range(0, 1));
      end
    end
    for (int k = 0; k < NR; k++) av[k*10 +: 10] = op[k];
    bus.req_i = pend;
    bus.a_i   = av;
    if (!m_act) begin
      if (pend != '0) begin
        m_w   = pick(pend, m_last);
        m_op  = int'(op[m_w]);
        m_act = 1'b1;
        m_t   = 1;
      end
    end else if (m_t == 14) begin
      m_act  = 1'b0;
      m_last = m_w;
    end else begin
      if (m_t == 13) m_y = isqrt(m_op);
      m_t++;
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_gnt",   32'(bus.gnt_o),      32'd0);
    chk("rst_done",  32'(bus.done_o),     32'd0);
    chk("rst_y",     32'(bus.y_o),        32'd0);
    chk("rst_busy",  32'(bus.busy_o),     32'd0);
    chk("rst_start", 32'(bus.sq_start_o), 32'd0);
    chk("rst_sq_a",  32'(bus.sq_a_o),     32'd0);
    model_reset();
    pend = '0; keep = '0; scram = '0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int bv[4] = '{0, 1, 1023, 255};
  int by[4] = '{0, 1, 31, 15};
  int cop[4] = '{16, 25, 36, 49};
  int c0, nd;

  initial begin
    for (int k = 0; k < NR; k++) op[k] = '0;
    bus.req_i = '0;
    bus.a_i   = '0;
    repeat (3) begin
      @(negedge clk);
      chk("init_busy", 32'(bus.busy_o), 32'd0);
      chk("init_y",    32'(bus.y_o),    32'd0);
    end
    rst_n = 1'b1;

    // Single request on requester 0
    pend[0] = 1'b1; op[0] = 10'd144;
    step(); c0 = cyc;
    run(15);
    chk("single_y", 32'(bus.y_o), 32'd12);
    chk("single_lat", (dlog.size() > 0) ? 32'(dlog[$] - c0) : 32'hFFFF, 32'd14);

    // Operand boundaries on requester 2
    for (int i = 0; i < 4; i++) begin
      pend[2] = 1'b1; op[2] = 10'(bv[i]);
      step(); c0 = cyc;
      run(15);
      chk("bnd_y", 32'(bus.y_o), 32'(by[i]));
      chk("bnd_lat", (dlog.size() > 0) ? 32'(dlog[$] - c0) : 32'hFFFF, 32'd14);
    end

    // Contention from a clean pointer
    apply_reset();
    glog.delete(); ylog.delete(); dlog.delete();
    for (int k = 0; k < NR; k++) begin
      pend[k] = 1'b1; keep[k] = 1'b1; op[k] = 10'(cop[k]);
    end
    for (int n = 0; n < 100 && glog.size() < 4; n++) step();
    pend = '0; keep = '0;
    run(20);
    chk("cont_cnt", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("cont_gnt", (i < glog.size()) ? 32'(glog[i]) : 32'hFFFF, FIXED ? 32'd0 : 32'(i));
      chk("cont_y", (i < ylog.size()) ? 32'(ylog[i]) : 32'hFFFF, FIXED ? 32'd4 : 32'(4 + i));
      if (i > 0)
        chk("cont_gap", (i < dlog.size()) ? 32'(dlog[i] - dlog[i-1]) : 32'hFFFF, 32'd15);
    end

    // Rotation: after requester 2, 0101 goes to requester 0 first
    pend[2] = 1'b1; op[2] = 10'd9;
    run(16);
    pend[0] = 1'b1; op[0] = 10'd64; pend[2] = 1'b1; op[2] = 10'd100;
    run(31);
    chk("rot_first",  (glog.size() >= 2) ? 32'(glog[$-1]) : 32'hFFFF, 32'd0);
    chk("rot_second", (glog.size() >= 1) ? 32'(glog[$])   : 32'hFFFF, 32'd2);

    // Operand changed after grant
    pend[1] = 1'b1; op[1] = 10'd200; scram[1] = 1'b1;
    run(16);
    scram[1] = 1'b0;
    chk("opchg_y", 32'(bus.y_o), 32'd14);

    // Random traffic, then drain
    rnd_en = 1'b1;
    run(1500);
    rnd_en = 1'b0; keep = '0; scram = '0;
    run(150);
    chk("drain_idle", 32'(bus.busy_o), 32'd0);

    // Reset in WAIT_DONE abandons the job
    pend[3] = 1'b1; op[3] = 10'd500;
    step();
    for (int n = 0; n < 20 && !(m_act && m_t == 8); n++) step();
    chk("rst_reach", (m_act && m_t == 8) ? 32'd1 : 32'd0, 32'd1);
    nd = dlog.size();
    apply_reset();
    run(3);
    chk("rst_nodone", 32'(dlog.size()), 32'(nd));
    pend[1] = 1'b1; op[1] = 10'd81;
    run(16);
    chk("post_rst_y", 32'(bus.y_o), 32'd9);
    chk("post_rst_done", 32'(dlog.size()), 32'(nd + 1));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end
endmodule

// File: doc/sqrt_arbiter.md
Name: sqrt_arbiter

Overview:
- Shares one `sqrt` unit (10-bit operand, 5-bit root, start/busy handshake) between NUM_REQ requesters.
- Arbitration is round-robin.
- Latches the winner's operand, sequences the unit through start, busy and done, and returns the root to the winner with a one-cycle done pulse.
- Sits between the requesting datapath blocks and the single `sqrt` instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, $clog2(NUM_REQ), width of the requester index and round-robin pointer.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NUM_REQ  per-requester request level.
- a_i  in  NUM_REQ*10  packed operands; requester k uses bits [10k+9:10k].
- gnt_o  out  NUM_REQ  one-hot, one-cycle pulse: operand accepted.
- done_o  out  NUM_REQ  one-hot, one-cycle pulse: result valid for that requester.
- y_o  out  5  last result; holds until the next done.
- busy_o  out  1  arbiter not in IDLE.
- sq_start_o  out  1  start strobe to the `sqrt` unit.
- sq_a_o  out  10  operand to the `sqrt` unit.
- sq_busy_i  in  2  `sqrt` busy; any nonzero value means busy.
- sq_y_i  in  5  `sqrt` result, valid once busy has fallen.

Behaviour:
- Reset (async, rst_ni=0): all outputs 0, state IDLE, round-robin pointer ptr=0.
  - Asserting reset mid-operation abandons the job silently; no done pulse is produced.
  - The system must also reset the `sqrt` unit.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - If req_i != 0, select winner w, the first set bit searching from ptr upward with wrap.
  - Latch w and a_i[w].
  - Go to ISSUE.
- ISSUE (1 cycle):
  - sq_start_o=1, sq_a_o=latched operand, gnt_o[w]=1.
  - Go to WAIT_BUSY.
- WAIT_BUSY:
  - Stay while sq_busy_i==0.
  - On sq_busy_i!=0, go to WAIT_DONE.
- WAIT_DONE:
  - Stay while sq_busy_i!=0.
  - On sq_busy_i==0, capture sq_y_i into y_o and go to RESP.
- RESP (1 cycle):
  - done_o[w]=1, y_o valid.
  - ptr <= (w+1) mod NUM_REQ.
  - Go to IDLE.
- sq_start_o is 0 outside ISSUE. sq_a_o holds the latched operand until the next ISSUE.
- Request rules:
  - req_i[k] and a_i[k] must be held stable until gnt_o[k].
  - After the grant, the requester may drop req_i[k]; a_i[k] is don't-care.
  - req_i[k] still high in the IDLE cycle after RESP counts as a new request.
- req_i changes while the arbiter is busy are ignored. Only IDLE samples req_i.
- Requests arriving while busy wait; none is lost while held.
- Simultaneous requests: exactly one grant per job. The others are served in rotating order, starting from the index after the last winner.
- Latency with the `sqrt` unit attached (11 busy cycles):
  - req_i sampled in IDLE at cycle 0.
  - ISSUE at cycle 1.
  - sq_busy_i high in cycles 2..12.
  - Capture in cycle 13.
  - done_o in cycle 14.
- Back-to-back throughput: one job per 15 cycles.
- Arithmetic: operands pass through unmodified; root is floor(sqrt(a)) computed by the unit.

Optional Feature:
- Macro: SQRT_ARB_FIXED_PRIO_EN.
- Defined:
  - Fixed priority; the lowest set index of req_i always wins.
  - ptr is not implemented; its update in RESP is removed.
- Undefined: round-robin as described above.

Test Plan:
- Single request, req_i=4'b0001, a_i[0]=144:
  - gnt_o=0001 at cycle 1.
  - sq_start_o=1 and sq_a_o=144 at cycle 1.
  - done_o=0001 and y_o=12 at cycle 14.
- Boundaries, requester 2:
  - a=0 -> y_o=0.
  - a=1 -> y_o=1.
  - a=1023 -> y_o=31.
  - a=255 -> y_o=15.
  - Each done_o=0100 at 14 cycles.
- Contention: req_i=4'b1111 held with operands 16, 25, 36, 49.
  - Default: grants in order 0,1,2,3; y_o=4,5,6,7; done pulses 15 cycles apart.
  - With SQRT_ARB_FIXED_PRIO_EN and req_i held: requester 0 wins every job.
- Rotation: grant requester 2, then req_i=4'b0101 -> next grant goes to requester 0 (ptr=3 wraps).
- Reset mid-job: rst_ni=0 during WAIT_DONE.
  - All outputs 0 immediately (asynchronous).
  - No done_o.
  - After release, req_i=0010 completes normally.
- Operand change after grant: alter a_i[1] after gnt_o[1] -> y_o still reflects the latched operand.
